// File: rtl/terrain_profile_gen.sv
// Per-scanline terrain height stream: LFSR noise smoothed by a leaky accumulator.
// Define TERRAIN_CRATER_EN to add the crater height overlay.
module terrain_profile_gen #(
  parameter int HEIGHT_BITS = 8,
  parameter int SHIFT_MAX   = 7,
  parameter int LFSR_BITS   = 16,
  parameter logic [LFSR_BITS-1:0] LFSR_TAPS = 16'hB400,
  parameter int X_BITS      = 10,
  localparam int SW         = $clog2(SHIFT_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [LFSR_BITS-1:0]   seed,
  input  logic [SW-1:0]          shift,
  input  logic [HEIGHT_BITS-1:0] base,
  input  logic [HEIGHT_BITS-1:0] h_min,
  input  logic [HEIGHT_BITS-1:0] h_max,
  input  logic                   crater_we,
  input  logic                   crater_clr,
  input  logic [X_BITS-1:0]      crater_x,
  input  logic [5:0]             crater_r,
  output logic [HEIGHT_BITS-1:0] height,
  output logic [X_BITS-1:0]      column,
  output logic                   valid
);

  localparam int H  = HEIGHT_BITS;
  localparam int A  = H + SHIFT_MAX;
  localparam int AW = A + 1;
  localparam logic [SW-1:0] SMAX = SW'(SHIFT_MAX);

  logic [LFSR_BITS-1:0] lfsr, lfsr_n;
  logic [A-1:0]         acc, acc_n;
  logic [AW-1:0]        acc_w;
  logic [SW-1:0]        shift_q, ls;
  logic [H-1:0]         r, h_cl, h_ovl, base_cl;
  logic [X_BITS-1:0]    col_new;

  // Floor is applied last so h_min wins when the bounds cross.
  function automatic logic [H-1:0] clamp(input logic [H-1:0] v);
    logic [H-1:0] t;
    t = (v > h_max) ? h_max : v;
    return (t < h_min) ? h_min : t;
  endfunction

  always_comb begin
    r       = lfsr[LFSR_BITS-1 -: H];
    lfsr_n  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    ls      = SMAX - shift_q;
    acc_w   = {1'b0, acc} - ({1'b0, acc} >> shift_q)
            + (AW'(r) << ls);
    acc_n   = acc_w[A-1:0];
    h_cl    = clamp(acc_n[A-1 -: H]);
    base_cl = clamp(base);
    if (!valid)
      col_new = '0;
    else if (column == '1)
      col_new = column;
    else
      col_new = column + 1'b1;
  end

`ifdef TERRAIN_CRATER_EN
  localparam int DW = X_BITS + 7;
  localparam int HW = H + 7;

  logic              armed;
  logic [X_BITS-1:0] cx;
  logic [5:0]        cr;
  logic [X_BITS-1:0] dist;
  logic [HW-1:0]     sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      cx    <= '0;
      cr    <= '0;
    end else if (crater_clr) begin
      armed <= 1'b0;
    end else if (crater_we) begin
      armed <= 1'b1;
      cx    <= crater_x;
      cr    <= crater_r;
    end
  end

  always_comb begin
    dist  = (col_new >= cx) ? col_new - cx : cx - col_new;
    sum   = HW'(h_cl) + HW'(DW'(cr) - DW'(dist));
    h_ovl = h_cl;
    if (armed && (DW'(dist) < DW'(cr)))
      h_ovl = (sum > HW'({H{1'b1}})) ? '1 : sum[H-1:0];
  end
`else
  logic unused_crater;
  assign unused_crater = ^{crater_we, crater_clr, crater_x, crater_r};
  assign h_ovl = h_cl;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr    <= LFSR_BITS'(1);
      acc     <= '0;
      shift_q <= SMAX;
      height  <= '0;
      column  <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      lfsr    <= (seed == '0) ? LFSR_BITS'(1) : seed;
      shift_q <= (shift > SMAX) ? SMAX : shift;
      acc     <= {base, {SHIFT_MAX{1'b0}}};
      height  <= base_cl;
      column  <= '0;
      valid   <= 1'b0;
    end else if (step) begin
      lfsr    <= lfsr_n;
      acc     <= acc_n;
      height  <= h_ovl;
      column  <= col_new;
      valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_terrain_profile_gen.sv
// Directed checks for terrain_profile_gen: reset, smoothing, raw noise,
// clamping, column saturation and the optional crater overlay.
module tb_terrain_profile_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        load, step;
  logic [15:0] seed;
  logic [2:0]  shift;
  logic [7:0]  base, h_min, h_max;
  logic        crater_we, crater_clr;
  logic [9:0]  crater_x;
  logic [5:0]  crater_r;
  logic [7:0]  height, height4;
  logic [9:0]  column;
  logic [3:0]  column4;
  logic        valid, valid4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  terrain_profile_gen dut (
    .clk(clk), .reset(reset), .load(load), .step(step),
    .seed(seed), .shift(shift), .base(base),
    .h_min(h_min), .h_max(h_max),
    .crater_we(crater_we), .crater_clr(crater_clr),
    .crater_x(crater_x), .crater_r(crater_r),
    .height(height), .column(column), .valid(valid)
  );

  terrain_profile_gen #(.X_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .step(step),
    .seed(seed), .shift(shift), .base(base),
    .h_min(h_min), .h_max(h_max),
    .crater_we(crater_we), .crater_clr(crater_clr),
    .crater_x(crater_x[3:0]), .crater_r(crater_r),
    .height(height4), .column(column4), .valid(valid4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int crater_exp(input int col);
`ifdef TERRAIN_CRATER_EN
    case (col)
      8:       return 102;
      10:      return 104;
      default: return 100;
    endcase
`else
    return (col >= 0) ? 100 : 100;
`endif
  endfunction

  initial begin
    reset = 1'b1; load = 1'b0; step = 1'b0;
    seed = 16'd0; shift = 3'd0; base = 8'd0;
    h_min = 8'd0; h_max = 8'd255;
    crater_we = 1'b0; crater_clr = 1'b0;
    crater_x = 10'd0; crater_r = 6'd0;
    tick(); tick();
    chk("rst_height", height, 0);
    chk("rst_column", column, 0);
    chk("rst_valid", valid, 0);
    reset = 1'b0;

    // smoothing at shift 7
    load = 1'b1; seed = 16'd1; base = 8'd100; shift = 3'd7;
    tick();
    chk("load_height", height, 100);
    chk("load_column", column, 0);
    chk("load_valid", valid, 0);
    load = 1'b0; step = 1'b1;
    tick();
    chk("s1_valid", valid, 1);
    chk("s1_column", column, 0);
    chk("s1_height", height, 99);
    tick();
    chk("s2_height", height, 99);
    chk("s2_column", column, 1);

    // asynchronous reset mid-line
    reset = 1'b1;
    #1;
    chk("arst_height", height, 0);
    chk("arst_column", column, 0);
    chk("arst_valid", valid, 0);
    step = 1'b0;
    tick();
    reset = 1'b0;

    // raw noise at shift 0
    load = 1'b1; seed = 16'hFFFF; shift = 3'd0; base = 8'd0;
    tick();
    load = 1'b0; step = 1'b1;
    tick(); chk("raw0", height, 8'hFF);
    tick(); chk("raw1", height, 8'hCB);
    tick(); chk("raw2", height, 8'hD1);
    tick(); chk("raw3", height, 8'hDC);
    tick(); chk("raw4", height, 8'hDA);
    chk("raw_col", column, 4);

    // zero seed is replaced by 1
    step = 1'b0; load = 1'b1; seed = 16'd0;
    tick();
    load = 1'b0; step = 1'b1;
    tick(); chk("seed0_a", height, 0);
    tick(); chk("seed0_b", height, 8'hB4);

    // clamping
    h_min = 8'd50; h_max = 8'd50;
    tick(); chk("clamp_eq", height, 50);
    tick(); chk("clamp_eq2", height, 50);
    h_min = 8'd60; h_max = 8'd40;
    tick(); chk("clamp_cross", height, 60);

    // 4-bit column saturation
    h_min = 8'd0; h_max = 8'd255;
    step = 1'b0; load = 1'b1;
    tick();
    load = 1'b0; step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("col4_%0d", i), column4, (i < 16) ? i : 15);
    end
    load = 1'b1;
    tick();
    chk("ld_wins_col", column4, 0);
    chk("ld_wins_valid", valid4, 0);

    // crater overlay on a flat profile
    h_min = 8'd100; h_max = 8'd100;
    step = 1'b0; seed = 16'd1; shift = 3'd7; base = 8'd100;
    crater_we = 1'b1; crater_x = 10'd10; crater_r = 6'd4;
    tick();
    crater_we = 1'b0; load = 1'b0; step = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 6 || i == 8 || i == 10 || i == 14)
        chk($sformatf("crater_col%0d", column), height, crater_exp(i));
    end
    step = 1'b0; load = 1'b1; crater_clr = 1'b1;
    tick();
    crater_clr = 1'b0; load = 1'b0; step = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 8 || i == 10)
        chk($sformatf("clr_col%0d", column), height, 100);
    end
    step = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
